jk_drive: RTL and testbench
===========================

JK_DRIVE -- requirements
Module: jk_drive

Interface
Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the number of JK state bits driven.
Ports
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port tgt_valid, input, 1 bit, meaning a target word is offered.
REQ-005 The block SHALL have port tgt_ready, output, 1 bit, meaning the block can accept a target word.
REQ-006 The block SHALL have port tgt_data, input, WIDTH bits, the requested next state.
REQ-007 The block SHALL have port j_out, output, WIDTH bits, the per-bit J drive.
REQ-008 The block SHALL have port k_out, output, WIDTH bits, the per-bit K drive.
REQ-009 The block SHALL have port q, output, WIDTH bits, the current JK bank state.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit, a sticky mismatch flag.
REQ-013 The block SHALL have port flips, output, clog2(WIDTH+1) bits, the number of bits changed by the last accepted target.

Function
REQ-014 The FSM SHALL have states IDLE, APPLY and CHECK, encoded in two bits.
REQ-015 tgt_ready SHALL equal 1 only in IDLE.
REQ-016 A transfer SHALL occur on a rising edge where tgt_valid and tgt_ready are both 1, called E0.
REQ-017 At E0 the block SHALL capture tgt_data into an internal target register.
REQ-018 At E0 flips SHALL load the population count of q XOR tgt_data.
REQ-019 At E0 the FSM SHALL move to APPLY.
REQ-020 In APPLY, j_out and k_out SHALL be the per-bit excitation of the current q toward the target.
REQ-021 Excitation for 0->0 SHALL be J=0, K=0.
REQ-022 Excitation for 1->1 SHALL be J=0, K=0.
REQ-023 Excitation for 0->1 SHALL be J=1, K=0.
REQ-024 Excitation for 1->0 SHALL be J=0, K=1.
REQ-025 Don't-care excitation terms SHALL always be driven 0.
REQ-026 Outside APPLY, j_out and k_out SHALL be all zeros, so the bank holds (JK code 00).
REQ-027 At the edge ending APPLY (E1), each bank bit SHALL update per JK semantics: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-028 At E1 the FSM SHALL move to CHECK.
REQ-029 In CHECK, done SHALL be 1 for exactly that cycle if q equals the target.
REQ-030 If q does not equal the target in CHECK, err SHALL be set at E2 and done SHALL stay 0.
REQ-031 At E2 the FSM SHALL move to IDLE.
REQ-032 Latency SHALL be fixed: done is high in the second cycle after E0, and one transfer completes per 3 cycles at most.
REQ-033 A target equal to q SHALL still traverse APPLY and CHECK, with j_out=k_out=0, flips=0 and done pulsed.
REQ-034 tgt_valid asserted while busy SHALL be ignored; tgt_data SHALL not be sampled until IDLE.
REQ-035 err SHALL remain set until reset.

Reset
REQ-036 While rst=1, q SHALL be 0, the target register 0, flips 0, err 0 and the FSM IDLE.
REQ-037 While rst=1, j_out, k_out and done SHALL be 0 and busy SHALL be 0.
REQ-038 Reset asserted mid-transfer (APPLY or CHECK) SHALL abort the transfer immediately, with no done pulse and no bank update.
REQ-039 tgt_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-040 Macro JK_DRIVE_TOGGLE_EN defined: every changing bit (0->1 or 1->0) SHALL use J=1, K=1 (toggle); unchanged bits SHALL use 00.
REQ-041 Macro JK_DRIVE_TOGGLE_EN undefined: the set/clear encodings of REQ-023 and REQ-024 SHALL apply.
REQ-042 Final q, done timing and flips SHALL be identical with and without JK_DRIVE_TOGGLE_EN.

Structure
REQ-043 Shared package jk_pkg SHALL hold the FSM state typedef and the JK code constants (HOLD=00, CLR=01, SET=10, TGL=11).
REQ-044 Sub-module jk_bank SHALL hold the WIDTH-bit JK register bank with asynchronous active-high reset, and nothing else.

Verification
REQ-045 Reset then transfer 8'hA5 -> APPLY shows j_out=A5, k_out=00; q=A5 after E1; done high in CHECK; flips=4.
REQ-046 Next transfer 8'h5A -> without the macro j_out=5A, k_out=A5; with the macro j_out=FF, k_out=FF; in both cases q=5A and flips=8.
REQ-047 Repeat transfer 8'h5A -> j_out=00, k_out=00, flips=0, done pulsed, q unchanged.
REQ-048 tgt_valid held high with changing data for 6 cycles -> exactly 2 transfers are accepted, each at a cycle where tgt_ready=1.
REQ-049 rst pulsed during APPLY of 8'hFF -> q=00, IDLE, no done, and tgt_ready=1 in the next cycle.
REQ-050 A bank bit forced to mismatch during APPLY -> err=1 at E2, done=0, and err holds through later good transfers.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: shared FSM state encoding and JK drive codes for jk_drive.
package jk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_APPLY = 2'b01;
    localparam state_t ST_CHECK = 2'b10;

    // JK codes as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_bank.sv
// jk_bank: WIDTH-bit bank of JK flip-flops, asynchronous active-high reset.
module jk_bank
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_k,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Per-bit JK update: hold, clear, set or toggle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({i_j[i], i_k[i]})
                    JK_HOLD: r_q[i] <= r_q[i];
                    JK_CLR:  r_q[i] <= 1'b0;
                    JK_SET:  r_q[i] <= 1'b1;
                    default: r_q[i] <= ~r_q[i];
                endcase
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_drive.sv
// jk_drive: accepts a target word, drives a JK bank toward it for one cycle,
// then verifies the result (done pulse on match, sticky err on mismatch).
// Optional macro JK_DRIVE_TOGGLE_EN: changing bits are driven with the toggle
// code instead of set/clear; the resulting bank state is identical.
//
// state    | meaning
// IDLE     | ready for a new target, bank held
// APPLY    | excitation driven, bank updates on the closing edge
// CHECK    | bank compared against target, done or err decided
module jk_drive
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int FW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [FW-1:0]    flips
);

    state_t           r_state;
    logic [WIDTH-1:0] r_tgt;
    logic [FW-1:0]    r_flips;
    logic             r_err;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_new_diff;
    logic [FW-1:0]    w_pop;
    logic             w_accept;
    logic             w_match;

    assign w_accept   = tgt_valid && (r_state == ST_IDLE);
    assign w_new_diff = w_q ^ tgt_data;
    assign w_match    = (w_q == r_tgt);

    // Number of bits the offered target would change.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + FW'(w_new_diff[i]);
        end
    end

    // Excitation toward the target, only while applying; zero means hold.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == ST_APPLY) begin
`ifdef JK_DRIVE_TOGGLE_EN
            w_j = w_q ^ r_tgt;
            w_k = w_q ^ r_tgt;
`else
            w_j = ~w_q & r_tgt;
            w_k = w_q & ~r_tgt;
`endif
        end
    end

    // Sequencer: capture target, apply for one cycle, check for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
            r_flips <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tgt   <= tgt_data;
                        r_flips <= w_pop;
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: r_state <= ST_CHECK;
                ST_CHECK: begin
                    if (!w_match) begin
                        r_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    jk_bank #(.WIDTH(WIDTH)) u_bank (
        .i_clk (clk),
        .i_rst (rst),
        .i_j   (w_j),
        .i_k   (w_k),
        .o_q   (w_q)
    );

    assign tgt_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_CHECK) && w_match;
    assign err       = r_err;
    assign flips     = r_flips;
    assign j_out     = w_j;
    assign k_out     = w_k;
    assign q         = w_q;

endmodule

// File: tb/tb_jk_drive.sv
// tb_jk_drive: randomized scoreboard bench for jk_drive (WIDTH=8).
module tb_jk_drive;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_data;
    logic [7:0] j_out;
    logic [7:0] k_out;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] flips;

    jk_drive #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .j_out     (j_out),
        .k_out     (k_out),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .flips     (flips)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] q;
        logic [3:0] flips;
        logic       done;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0] qm = 8'h00;
    logic       em = 1'b0;
    int         phase = 0;   // 0 idle, 1 applying, 2 checking
    int         dut_accepts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; offers (v,d) for the next rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input bit corrupt);
        exp_t e;
        tgt_valid = v;
        tgt_data  = d;
        chk("tgt_ready", 32'(tgt_ready), 32'(phase == 0));
        if (v && tgt_ready) dut_accepts++;
        @(posedge clk);
        if (v && phase == 0) begin
            e.j = 8'h00;
            e.k = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (d[b] != qm[b]) begin
`ifdef JK_DRIVE_TOGGLE_EN
                    e.j[b] = 1'b1;
                    e.k[b] = 1'b1;
`else
                    if (d[b]) e.j[b] = 1'b1;
                    else      e.k[b] = 1'b1;
`endif
                end
            end
            e.flips = 4'($countones(qm ^ d));
            e.done  = !corrupt;
            e.q     = corrupt ? qm : d;
            if (corrupt) em = 1'b1;
            qm = e.q;
            sb.push_back(e);
            phase = 1;
        end else if (phase == 1) begin
            phase = 2;
        end else begin
            phase = 0;
        end
        @(negedge clk);
    endtask

    // Monitor: pops an expectation each time the DUT reaches its check cycle.
    initial begin
        int         mcnt;
        logic [7:0] cj;
        logic [7:0] ck;
        exp_t       e;
        mcnt = 0;
        cj = '0;
        ck = '0;
        forever begin
            @(posedge clk);
            #1;
            if (busy) begin
                mcnt++;
                if (mcnt == 1) begin
                    cj = j_out;
                    ck = k_out;
                end else if (mcnt == 2) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_transfer: got a check cycle, required none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("j_out", 32'(cj), 32'(e.j));
                        chk("k_out", 32'(ck), 32'(e.k));
                        chk("q", 32'(q), 32'(e.q));
                        chk("flips", 32'(flips), 32'(e.flips));
                        chk("done", 32'(done), 32'(e.done));
                    end
                end
            end else begin
                mcnt = 0;
                chk("idle_jk", 32'({j_out, k_out}), 32'(0));
                chk("idle_done", 32'(done), 32'(0));
                chk("idle_err", 32'(err), 32'(em));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_flips", 32'(flips), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        rst = 1'b0;

        // directed sequence
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);

        // valid held with changing data: two acceptances in six cycles
        dut_accepts = 0;
        for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0);
        chk("held_valid_accepts", 32'(dut_accepts), 32'(2));

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end

        // reset during APPLY
        while (phase != 0) drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        rst = 1'b1;
        sb.delete();
        qm = 8'h00;
        em = 1'b0;
        phase = 0;
        #1;
        chk("abort_q", 32'(q), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_jk", 32'({j_out, k_out}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        tgt_valid = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("abort_q_after", 32'(q), 32'(0));

        // bank forced to hold during APPLY -> mismatch
        drive(1'b1, 8'h3C, 1'b1);
        force dut.w_j = 8'h00;
        force dut.w_k = 8'h00;
        drive(1'b0, 8'h00, 1'b0);
        release dut.w_j;
        release dut.w_k;
        drive(1'b0, 8'h00, 1'b0);
        chk("err_set", 32'(err), 32'(1));

        // later good transfers keep err set
        for (int i = 0; i < 30; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        chk("err_sticky", 32'(err), 32'(1));
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
